// File: rtl/cpld_ctrl_cfg_seq_if.sv
// AXI4-Lite bus between the CPLD configuration sequencer (master) and the CPLD_ctrl slave.
interface cpld_ctrl_cfg_seq_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/cpld_ctrl_cfg_seq.sv
// AXI4-Lite master writing a fixed register table into CPLD_ctrl after a start pulse.
// Define CPLD_CFG_READBACK_VERIFY_EN to read back and compare every entry after its write.
module cpld_ctrl_cfg_seq #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 4,
  localparam int unsigned IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [N_ENTRIES*ADDR_WIDTH-1:0] tbl_addr,
  input  logic [N_ENTRIES*DATA_WIDTH-1:0] tbl_data,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      err_code,
  output logic [IDX_W-1:0]                err_index,
  cpld_ctrl_cfg_seq_if.master             m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
`ifdef CPLD_CFG_READBACK_VERIFY_EN
    S_RA,
    S_RD,
`endif
    S_NEXT,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [IDX_W-1:0]      err_index_q, err_index_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_hs, w_hs, load_wr, finish;

  assign aw_hs = awvalid_q & m_axi.M_AXI_AWREADY;
  assign w_hs  = wvalid_q & m_axi.M_AXI_WREADY;

`ifdef CPLD_CFG_READBACK_VERIFY_EN
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  load_rd;
`else
  logic unused_rd;
  assign unused_rd = ^{m_axi.M_AXI_ARREADY, m_axi.M_AXI_RDATA,
                       m_axi.M_AXI_RRESP, m_axi.M_AXI_RVALID};
`endif

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_code_q  <= 2'd0;
      err_index_q <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
`ifdef CPLD_CFG_READBACK_VERIFY_EN
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
`ifdef CPLD_CFG_READBACK_VERIFY_EN
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      araddr_q    <= araddr_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    load_wr     = 1'b0;
    finish      = 1'b0;
`ifdef CPLD_CFG_READBACK_VERIFY_EN
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    araddr_d    = araddr_q;
    load_rd     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR;
          idx_d       = '0;
          err_code_d  = 2'd0;
          err_index_d = '0;
          busy_d      = 1'b1;
          load_wr     = 1'b1;
        end
      end
      S_WR: begin
        // Each VALID stays up until its own handshake; channels finish independently
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = S_WB;
          bready_d = 1'b1;
        end
      end
      S_WB: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (m_axi.M_AXI_BRESP != 2'b00) begin
            err_code_d  = 2'd1;
            err_index_d = idx_q;
            finish      = 1'b1;
          end else begin
`ifdef CPLD_CFG_READBACK_VERIFY_EN
            state_d   = S_RA;
            arvalid_d = 1'b1;
            load_rd   = 1'b1;
`else
            state_d   = S_NEXT;
`endif
          end
        end
      end
`ifdef CPLD_CFG_READBACK_VERIFY_EN
      S_RA: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (m_axi.M_AXI_RRESP != 2'b00) begin
            err_code_d  = 2'd2;
            err_index_d = idx_q;
            finish      = 1'b1;
          end else if (m_axi.M_AXI_RDATA != tbl_data[idx_q*DATA_WIDTH +: DATA_WIDTH]) begin
            err_code_d  = 2'd3;
            err_index_d = idx_q;
            finish      = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
`endif
      S_NEXT: begin
        if (idx_q == IDX_W'(N_ENTRIES - 1)) begin
          finish = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_WR;
          load_wr = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      state_d = S_FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    // Present the entry selected by idx_d together with both write VALIDs
    if (load_wr) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = tbl_addr[idx_d*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d   = tbl_data[idx_d*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef CPLD_CFG_READBACK_VERIFY_EN
    if (load_rd) begin
      araddr_d = tbl_addr[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
    end
`endif
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
`ifdef CPLD_CFG_READBACK_VERIFY_EN
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
`else
  assign m_axi.M_AXI_ARADDR  = '0;
  assign m_axi.M_AXI_ARVALID = 1'b0;
  assign m_axi.M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_cpld_ctrl_cfg_seq.sv
// Directed bench for cpld_ctrl_cfg_seq with a behavioural CPLD_ctrl AXI4-Lite slave.
module tb_cpld_ctrl_cfg_seq;

`ifdef CPLD_CFG_READBACK_VERIFY_EN
  localparam int PER = 5;
`else
  localparam int PER = 3;
`endif

  logic        clk, rst_n, start;
  logic [15:0] tbl_addr;
  logic [127:0] tbl_data;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [1:0]  err_index;

  int tests, fails;

  cpld_ctrl_cfg_seq_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  cpld_ctrl_cfg_seq #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .N_ENTRIES(4)) dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .start    (start),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .busy     (busy),
    .done     (done),
    .err_code (err_code),
    .err_index(err_index),
    .m_axi    (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: programmable AW/W latency, BRESP error and read corruption injection
  int          aw_lat, w_lat, aw_cnt, w_cnt;
  logic        err_en, corrupt_en;
  logic [3:0]  err_addr;
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [1:0]  bresp_r;
  logic [3:0]  aw_addr_l;
  logic [31:0] w_data_l, rdata_r;
  logic [31:0] mem [4];
  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  b_addr;
  logic [31:0] b_data;

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt >= aw_lat);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && (w_cnt >= w_lat);
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
  assign axi.M_AXI_BVALID  = bvalid_r;
  assign axi.M_AXI_BRESP   = bresp_r;
  assign axi.M_AXI_RVALID  = rvalid_r;
  assign axi.M_AXI_RDATA   = rdata_r;
  assign axi.M_AXI_RRESP   = 2'b00;
  assign aw_hs  = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
  assign w_hs   = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
  assign ar_hs  = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;
  assign b_addr = aw_hs ? axi.M_AXI_AWADDR : aw_addr_l;
  assign b_data = w_hs ? axi.M_AXI_WDATA : w_data_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_r <= 1'b0; bresp_r <= 2'b00; rvalid_r <= 1'b0; rdata_r <= '0;
      aw_addr_l <= '0; w_data_l <= '0;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (axi.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt <= 0;  else if (axi.M_AXI_WVALID)  w_cnt <= w_cnt + 1;
      if (bvalid_r && axi.M_AXI_BREADY) begin
        bvalid_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= axi.M_AXI_AWADDR; end
        if (w_hs)  begin w_got <= 1'b1;  w_data_l <= axi.M_AXI_WDATA;  end
        if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid_r) begin
          bvalid_r <= 1'b1;
          if (err_en && b_addr == err_addr) bresp_r <= 2'b10;
          else begin bresp_r <= 2'b00; mem[b_addr[3:2]] <= b_data; end
        end
      end
      if (ar_hs) begin
        rvalid_r <= 1'b1;
        rdata_r  <= (corrupt_en && axi.M_AXI_ARADDR == 4'h4) ? 32'hDEAD
                                                              : mem[axi.M_AXI_ARADDR[3:2]];
      end else if (rvalid_r && axi.M_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Event counters and protocol monitor
  int aw_n, b_n, ar_n, done_n, busy_n, viol_n;
  logic p_av, p_ah, p_wv, p_wh;
  initial begin
    aw_n = 0; b_n = 0; ar_n = 0; done_n = 0; busy_n = 0; viol_n = 0;
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      p_av <= 1'b0; p_ah <= 1'b0; p_wv <= 1'b0; p_wh <= 1'b0;
    end else begin
      aw_n   <= aw_n + int'(aw_hs);
      b_n    <= b_n + int'(axi.M_AXI_BVALID && axi.M_AXI_BREADY);
      ar_n   <= ar_n + int'(ar_hs);
      done_n <= done_n + int'(done);
      busy_n <= busy_n + int'(busy);
      viol_n <= viol_n + int'(p_av && !p_ah && !axi.M_AXI_AWVALID)
                       + int'(p_wv && !p_wh && !axi.M_AXI_WVALID)
                       + int'(p_ah && axi.M_AXI_AWVALID)
                       + int'(p_wh && axi.M_AXI_WVALID)
                       + int'(axi.M_AXI_AWVALID && axi.M_AXI_ARVALID);
      p_av <= axi.M_AXI_AWVALID; p_ah <= aw_hs;
      p_wv <= axi.M_AXI_WVALID;  p_wh <= w_hs;
    end
  end

  int s_aw, s_b, s_ar, s_done, s_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_aw = aw_n; s_b = b_n; s_ar = ar_n; s_done = done_n; s_busy = busy_n;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Wait (bounded) for done, then confirm it is a single-cycle pulse with busy low
  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk); n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; tbl_addr = '0; tbl_data = '0;
    aw_lat = 0; w_lat = 0; err_en = 1'b0; corrupt_en = 1'b0; err_addr = 4'h8;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_err_index", 32'(err_index), 0);
    chk("rst_awvalid", 32'(axi.M_AXI_AWVALID), 0);
    chk("rst_wvalid", 32'(axi.M_AXI_WVALID), 0);
    chk("rst_arvalid", 32'(axi.M_AXI_ARVALID), 0);
    chk("rst_awaddr", 32'(axi.M_AXI_AWADDR), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: zero-wait slave, addrs 0,4,8,C data 1..4
    tbl_addr = {4'hC, 4'h8, 4'h4, 4'h0};
    tbl_data = {32'd4, 32'd3, 32'd2, 32'd1};
    snap();
    pulse_start();
    chk("t1_busy_on", 32'(busy), 1);
    chk("t1_awvalid", 32'(axi.M_AXI_AWVALID), 1);
    chk("t1_wvalid", 32'(axi.M_AXI_WVALID), 1);
    chk("t1_wdata0", axi.M_AXI_WDATA, 32'd1);
    wait_done("t1", 200);
    chk("t1_busy_cycles", 32'(busy_n - s_busy), 32'(4 * PER));
    chk("t1_done_count", 32'(done_n - s_done), 1);
    chk("t1_aw_count", 32'(aw_n - s_aw), 4);
    chk("t1_b_count", 32'(b_n - s_b), 4);
`ifdef CPLD_CFG_READBACK_VERIFY_EN
    chk("t1_ar_count", 32'(ar_n - s_ar), 4);
`else
    chk("t1_ar_count", 32'(ar_n - s_ar), 0);
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t1_mem%0d", i), mem[i], 32'(i + 1));
    chk("t1_err_code", 32'(err_code), 0);
    chk("t1_err_index", 32'(err_index), 0);

    // 2: WREADY three cycles ahead of AWREADY
    aw_lat = 3;
    tbl_data = {32'h44, 32'h33, 32'h22, 32'h11};
    snap();
    pulse_start();
    wait_done("t2", 300);
    chk("t2_busy_cycles", 32'(busy_n - s_busy), 32'(4 * (PER + 3)));
    chk("t2_aw_count", 32'(aw_n - s_aw), 4);
    chk("t2_b_count", 32'(b_n - s_b), 4);
    chk("t2_mem0", mem[0], 32'h11);
    chk("t2_mem3", mem[3], 32'h44);
    chk("t2_err_code", 32'(err_code), 0);
    chk("t2_protocol", 32'(viol_n), 0);
    aw_lat = 0;

    // 3: BRESP error on entry 2 (address 0x8)
    err_en = 1'b1;
    tbl_data = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    snap();
    pulse_start();
    wait_done("t3", 200);
    chk("t3_err_code", 32'(err_code), 1);
    chk("t3_err_index", 32'(err_index), 2);
    chk("t3_aw_count", 32'(aw_n - s_aw), 3);
    chk("t3_b_count", 32'(b_n - s_b), 3);
    chk("t3_done_count", 32'(done_n - s_done), 1);
    chk("t3_busy_cycles", 32'(busy_n - s_busy), 32'(2 * PER + 2));
    chk("t3_mem3_untouched", mem[3], 32'h44);
    repeat (5) @(negedge clk);
    chk("t3_err_held", 32'(err_code), 1);
    err_en = 1'b0;

`ifdef CPLD_CFG_READBACK_VERIFY_EN
    // 4: readback of register 1 returns 0xDEAD
    corrupt_en = 1'b1;
    tbl_data = {32'd4, 32'd3, 32'd2, 32'd1};
    snap();
    pulse_start();
    wait_done("t4", 200);
    chk("t4_err_code", 32'(err_code), 3);
    chk("t4_err_index", 32'(err_index), 1);
    chk("t4_aw_count", 32'(aw_n - s_aw), 2);
    chk("t4_busy_cycles", 32'(busy_n - s_busy), 9);
    chk("t4_mem2_untouched", mem[2], 32'h33);
    corrupt_en = 1'b0;
`endif

    // 5: reset while AWVALID is up on entry 1, then rerun from entry 0
    aw_lat = 2;
    tbl_addr = {4'h0, 4'h4, 4'h8, 4'hC};
    tbl_data = {32'h54, 32'h53, 32'h52, 32'h51};
    pulse_start();
    chk("t5_err_cleared", 32'(err_code), 0);
    for (int n = 0; n < 100 && !(axi.M_AXI_AWVALID === 1'b1 && axi.M_AXI_AWADDR === 4'h8); n++)
      @(negedge clk);
    chk("t5_on_entry1", 32'(axi.M_AXI_AWADDR), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_awvalid", 32'(axi.M_AXI_AWVALID), 0);
    chk("t5_rst_wvalid", 32'(axi.M_AXI_WVALID), 0);
    chk("t5_rst_bready", 32'(axi.M_AXI_BREADY), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_awaddr", 32'(axi.M_AXI_AWADDR), 0);
    chk("t5_rst_wdata", axi.M_AXI_WDATA, 0);
    @(negedge clk); rst_n = 1'b1; aw_lat = 0;
    @(negedge clk);
    pulse_start();
    chk("t5_restart_awaddr", 32'(axi.M_AXI_AWADDR), 32'hC);
    chk("t5_restart_wdata", axi.M_AXI_WDATA, 32'h51);
    wait_done("t5", 200);
    chk("t5_mem3", mem[3], 32'h51);
    chk("t5_mem0", mem[0], 32'h54);
    chk("t5_err_code", 32'(err_code), 0);

    // 6: start pulses while busy and on the done cycle are ignored
    tbl_addr = {4'hC, 4'h8, 4'h4, 4'h0};
    tbl_data = {32'h64, 32'h63, 32'h62, 32'h61};
    snap();
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 200 && done !== 1'b1; n++) @(negedge clk);
    chk("t6_done_seen", 32'(done), 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_done_count", 32'(done_n - s_done), 1);
    chk("t6_aw_count", 32'(aw_n - s_aw), 4);
    chk("t6_busy_cycles", 32'(busy_n - s_busy), 32'(4 * PER));
    chk("t6_mem3", mem[3], 32'h64);
    chk("t6_protocol", 32'(viol_n), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
